// File: rtl/frame_strobe_gen_if.sv
// Request channel into the column frame strobe generator: a valid/ready
// handshake that carries the target column, frame index and frame payload.
interface frame_strobe_gen_if #(
    parameter int ColBits         = 5,
    parameter int FrameIdxBits    = 5,
    parameter int FrameBitsPerRow = 32
);
    logic                       req_valid;
    logic                       req_ready;
    logic [ColBits-1:0]         req_col;
    logic [FrameIdxBits-1:0]    req_frame;
    logic [FrameBitsPerRow-1:0] req_data;

    // Requester side: drives the request, watches ready
    modport master (
        output req_valid,
        output req_col,
        output req_frame,
        output req_data,
        input  req_ready
    );

    // Generator side: samples the request, drives ready
    modport slave (
        input  req_valid,
        input  req_col,
        input  req_frame,
        input  req_data,
        output req_ready
    );
endinterface

// File: rtl/frame_strobe_gen.sv
// Per-column configuration frame strobe generator.
// Accepts frame-write requests addressed to this column, presents the frame
// data to the column's term tiles, and pulses one FrameStrobe line with
// programmable setup, strobe and hold phases around it.
module frame_strobe_gen #(
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int FrameIdxBits    = 5,
    parameter int ColBits         = 5,
    parameter int ColumnID        = 0,
    parameter int SetupCycles     = 1,
    parameter int StrobeCycles    = 1,
    parameter int HoldCycles      = 1
) (
    input  logic                       UserCLK,
    input  logic                       rst,
    frame_strobe_gen_if.slave          req,
    output logic [FrameBitsPerRow-1:0] FrameData,
    output logic [MaxFramesPerCol-1:0] FrameStrobe,
    output logic                       busy,
    output logic                       addr_err,
    output logic [15:0]                strobe_cnt
);

    localparam int CntW = 16;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD
    } state_t;

    state_t                     r_state;
    logic [CntW-1:0]            r_cnt;
    logic [FrameIdxBits-1:0]    r_idx;
    logic [FrameBitsPerRow-1:0] r_frameData;
    logic [MaxFramesPerCol-1:0] r_frameStrobe;
    logic                       r_busy;
    logic                       r_addrErr;
    logic [15:0]                r_strobeCnt;
    logic                       r_reqReady;

    logic w_accept;
    logic w_colMatch;
    logic w_frameInRange;

    assign w_accept       = req.req_valid && r_reqReady;
    assign w_colMatch     = (req.req_col == ColBits'(ColumnID));
    assign w_frameInRange = (int'(req.req_frame) < MaxFramesPerCol);

    // Write-phase sequencer; every output is a register updated here
    always_ff @(posedge UserCLK) begin
        if (rst) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_idx         <= '0;
            r_frameData   <= '0;
            r_frameStrobe <= '0;
            r_busy        <= 1'b0;
            r_addrErr     <= 1'b0;
            r_strobeCnt   <= '0;
            r_reqReady    <= 1'b1;
        end else begin
            r_addrErr <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept && w_colMatch) begin
                        if (!w_frameInRange) begin
                            r_addrErr <= 1'b1;
                        end else begin
                            r_frameData <= req.req_data;
                            r_idx       <= req.req_frame;
                            r_cnt       <= CntW'(SetupCycles - 1);
                            r_state     <= SETUP;
                            r_busy      <= 1'b1;
                            r_reqReady  <= 1'b0;
                        end
                    end
                end
                SETUP: begin
                    if (r_cnt == '0) begin
                        r_cnt         <= CntW'(StrobeCycles - 1);
                        r_frameStrobe <= MaxFramesPerCol'(1) << r_idx;
                        r_state       <= STROBE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                STROBE: begin
                    if (r_cnt == '0) begin
                        r_frameStrobe <= '0;
                        r_strobeCnt   <= r_strobeCnt + 16'd1;
                        r_cnt         <= CntW'(HoldCycles - 1);
                        r_state       <= HOLD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (r_cnt == '0) begin
                        r_state    <= IDLE;
                        r_busy     <= 1'b0;
                        r_reqReady <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign req.req_ready = r_reqReady;
    assign FrameData     = r_frameData;
    assign FrameStrobe   = r_frameStrobe;
    assign busy          = r_busy;
    assign addr_err      = r_addrErr;
    assign strobe_cnt    = r_strobeCnt;

endmodule
